// File: rtl/io_bus_arbiter.sv
//------------------------------------------------------------------------------
// io_bus_arbiter : two-requester arbiter that serialises accesses to the IO bus
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter bit RR         = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req,
  input  logic [7:0]            m0_addr,
  input  logic                  m0_we,
  input  logic                  m0_rd,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [7:0]            m1_addr,
  input  logic                  m1_we,
  input  logic                  m1_rd,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [7:0]            io_addr,
  output logic [DATA_WIDTH-1:0] io_dout,
  input  logic [DATA_WIDTH-1:0] io_din,
  output logic                  io_we,
  output logic                  io_rd,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last;
  logic   r_win;

  logic                  w_win;
  logic [7:0]            w_addr;
  logic                  w_we;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_err;

  // Requester 1 wins when alone, or on a round-robin tie after requester 0 was last served.
  assign w_win   = m1_req && (!m0_req || (RR && !r_last));
  assign w_addr  = w_win ? m1_addr  : m0_addr;
  assign w_we    = w_win ? m1_we    : m0_we;
  assign w_rd    = w_win ? m1_rd    : m0_rd;
  assign w_wdata = w_win ? m1_wdata : m0_wdata;
  assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr > 8'h18) || (w_we == w_rd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_win    <= 1'b0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      io_addr  <= '0;
      io_dout  <= '0;
      io_we    <= 1'b0;
      io_rd    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_req || m1_req) begin
            r_win  <= w_win;
            r_last <= w_win;
            busy   <= 1'b1;
            if (w_win) m1_rdata <= '0;
            else       m0_rdata <= '0;
            if (w_err) begin
              // Rejected requests skip the bus cycle entirely.
              r_state <= ACK;
              if (w_win) begin
                m1_ack <= 1'b1;
                m1_err <= 1'b1;
              end else begin
                m0_ack <= 1'b1;
                m0_err <= 1'b1;
              end
            end else begin
              r_state <= BUS;
              io_addr <= w_addr;
              io_dout <= w_wdata;
              io_we   <= w_we;
              io_rd   <= w_rd;
            end
          end
        end
        BUS: begin
          r_state <= ACK;
          io_we   <= 1'b0;
          io_rd   <= 1'b0;
          if (r_win) begin
            m1_ack <= 1'b1;
            if (io_rd) m1_rdata <= io_din;
          end else begin
            m0_ack <= 1'b1;
            if (io_rd) m0_rdata <= io_din;
          end
        end
        ACK: begin
          r_state <= IDLE;
          m0_ack  <= 1'b0;
          m0_err  <= 1'b0;
          m1_ack  <= 1'b0;
          m1_err  <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
//------------------------------------------------------------------------------
// tb_io_bus_arbiter : directed and randomized checks of io_bus_arbiter
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_bus_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req[2];
  logic [7:0]  addr[2];
  logic        we[2];
  logic        rd[2];
  logic [31:0] wdata[2];

  logic        ack[2];
  logic        err[2];
  logic [31:0] rdata[2];
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic [31:0] io_din;
  logic        io_we;
  logic        io_rd;
  logic        busy;

  logic        a0_ack[2];
  logic        a0_err[2];
  logic [31:0] a0_rdata[2];
  logic [7:0]  io0_addr;
  logic [31:0] io0_dout;
  logic [31:0] io0_din;
  logic        io0_we;
  logic        io0_rd;
  logic        busy0;

  // IO unit stand-in: read data is a fixed function of the offset.
  function automatic logic [31:0] io_rom(input logic [7:0] a);
    if (a == 8'h14) return 32'h0000_1234;
    return {a, ~a, 8'hC3, a};
  endfunction

  assign io_din  = io_rom(io_addr);
  assign io0_din = io_rom(io0_addr);

  io_bus_arbiter #(.DATA_WIDTH(32), .RR(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_we(we[0]), .m0_rd(rd[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack[0]), .m0_err(err[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_we(we[1]), .m1_rd(rd[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack[1]), .m1_err(err[1]), .m1_rdata(rdata[1]),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .io_we(io_we), .io_rd(io_rd), .busy(busy)
  );

  io_bus_arbiter #(.DATA_WIDTH(32), .RR(1'b0)) dut_fp (
    .clk(clk), .rstn(rstn),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_we(we[0]), .m0_rd(rd[0]), .m0_wdata(wdata[0]),
    .m0_ack(a0_ack[0]), .m0_err(a0_err[0]), .m0_rdata(a0_rdata[0]),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_we(we[1]), .m1_rd(rd[1]), .m1_wdata(wdata[1]),
    .m1_ack(a0_ack[1]), .m1_err(a0_err[1]), .m1_rdata(a0_rdata[1]),
    .io_addr(io0_addr), .io_dout(io0_dout), .io_din(io0_din),
    .io_we(io0_we), .io_rd(io0_rd), .busy(busy0)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: last-served requester and each requester's visible read data.
  int          ptr = 1;
  logic [31:0] exp_rdata[2];

  logic        s_req[2];
  logic [7:0]  s_addr[2];
  logic        s_we[2];
  logic        s_rd[2];
  logic [31:0] s_wdata[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic [7:0] a,
                         input logic w, input logic d, input logic [31:0] x);
    s_req[i] = r; s_addr[i] = a; s_we[i] = w; s_rd[i] = d; s_wdata[i] = x;
  endtask

  function automatic logic [7:0] rnd_addr();
    int r = $urandom_range(0, 9);
    if (r < 7)  return 8'(r * 4);
    if (r == 7) return 8'h06;
    if (r == 8) return 8'h1C;
    return 8'($urandom);
  endfunction

  task automatic rnd_req(input int i, input logic r);
    int k = $urandom_range(0, 5);
    logic w = (k == 1) || (k == 2) || (k == 4);
    logic d = (k == 1) || (k == 3) || (k == 5);
    set_req(i, r, rnd_addr(), w, d, $urandom);
  endtask

  // One arbitrated access starting in an IDLE cycle; chk_fp also checks the
  // fixed-priority instance, which must always serve requester 0.
  task automatic txn(input bit chk_fp);
    int          w;
    int          o;
    bit          e_err;
    logic [7:0]  a;
    logic        d;
    logic [31:0] e_rd;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ack", {ack[1], ack[0]}, 0);
    for (int i = 0; i < 2; i++) begin
      req[i] = s_req[i]; addr[i] = s_addr[i]; we[i] = s_we[i];
      rd[i] = s_rd[i]; wdata[i] = s_wdata[i];
    end
    if (req[0] && req[1]) w = 1 - ptr;
    else                  w = req[1] ? 1 : 0;
    o     = 1 - w;
    ptr   = w;
    a     = addr[w];
    d     = rd[w];
    e_err = (a % 4 != 0) || (a > 8'h18) || (we[w] == rd[w]);
    @(negedge clk);
    if (e_err) begin
      chk("err_ack", ack[w], 1);
      chk("err_flag", err[w], 1);
      chk("err_rdata", rdata[w], 0);
      chk("err_other_ack", ack[o], 0);
      chk("err_no_we", io_we, 0);
      chk("err_no_rd", io_rd, 0);
      chk("err_busy", busy, 1);
      exp_rdata[w] = 32'h0;
    end else begin
      chk("bus_we", io_we, we[w]);
      chk("bus_rd", io_rd, rd[w]);
      chk("bus_addr", io_addr, a);
      chk("bus_dout", io_dout, wdata[w]);
      chk("bus_no_ack", {ack[1], ack[0]}, 0);
      chk("bus_busy", busy, 1);
      if (chk_fp) chk("fp_bus_dout", io0_dout, wdata[0]);
      addr[w] = 8'($urandom); wdata[w] = $urandom; rd[w] = ~rd[w];
      @(negedge clk);
      e_rd = d ? io_rom(a) : 32'h0;
      chk("ack_winner", ack[w], 1);
      chk("ack_err", err[w], 0);
      chk("ack_rdata", rdata[w], e_rd);
      chk("ack_other", ack[o], 0);
      chk("ack_other_rdata", rdata[o], exp_rdata[o]);
      chk("ack_no_we", io_we, 0);
      chk("ack_no_rd", io_rd, 0);
      if (chk_fp) begin
        chk("fp_ack0", a0_ack[0], 1);
        chk("fp_ack1", a0_ack[1], 0);
      end
      exp_rdata[w] = e_rd;
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = 8'h0; we[i] = 1'b0; rd[i] = 1'b0; wdata[i] = 32'h0;
      exp_rdata[i] = 32'h0;
      set_req(i, 1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
    end

    repeat (3) @(negedge clk);
    chk("rst_io", {io_addr, io_we, io_rd, busy}, 0);
    chk("rst_dout", io_dout, 0);
    chk("rst_ack", {ack[1], err[1], ack[0], err[0]}, 0);
    chk("rst_rdata0", rdata[0], 0);
    chk("rst_rdata1", rdata[1], 0);
    rstn = 1'b1;

    set_req(0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0000_A5A5);
    set_req(1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    txn(1'b0);
    set_req(0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    set_req(1, 1'b1, 8'h14, 1'b0, 1'b1, 32'h0);
    txn(1'b0);
    for (int t = 0; t < 4; t++) begin
      set_req(0, 1'b1, 8'(4 * t), 1'b1, 1'b0, 32'h1000_0000 + t);
      set_req(1, 1'b1, 8'(4 * t + 4), 1'b1, 1'b0, 32'h2000_0000 + t);
      txn(1'b1);
    end

    set_req(1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    set_req(0, 1'b1, 8'h06, 1'b1, 1'b0, 32'h1);
    txn(1'b0);
    set_req(0, 1'b1, 8'h1C, 1'b0, 1'b1, 32'h2);
    txn(1'b0);
    set_req(0, 1'b1, 8'h00, 1'b1, 1'b1, 32'h3);
    txn(1'b0);
    set_req(0, 1'b1, 8'h18, 1'b0, 1'b0, 32'h4);
    txn(1'b0);

    // Reset while the bus strobe is active.
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 8'h08; we[0] = 1'b1; rd[0] = 1'b0; wdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    chk("mid_we_before", io_we, 1);
    rstn = 1'b0;
    #1;
    chk("mid_we_drop", io_we, 0);
    chk("mid_busy_drop", busy, 0);
    chk("mid_no_ack", ack[0], 0);
    req[0] = 1'b0;
    ptr = 1;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_ack", {ack[1], ack[0]}, 0);
    end
    set_req(0, 1'b1, 8'h0C, 1'b1, 1'b0, 32'h0BAD_BEEF);
    set_req(1, 1'b1, 8'h10, 1'b1, 1'b0, 32'h0D0D_0D0D);
    txn(1'b0);

    for (int t = 0; t < 40; t++) begin
      logic r0;
      r0 = 1'($urandom_range(0, 1));
      rnd_req(0, r0);
      rnd_req(1, r0 ? 1'($urandom_range(0, 1)) : 1'b1);
      txn(1'b0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single IO bus of the IO unit (led, switches, seven-segment, swx and cnt registers) between two requesters.
- Requester 0 is the CPU memory stage; requester 1 is the debug/step unit.
- Serialises accesses so that exactly one requester drives io_addr/io_dout/io_we/io_rd in any cycle.
- Side-effecting reads (io_rd clears swx_vld) are therefore issued once, and only for the granted requester.

Parameters:
- DATA_WIDTH, 32, width of write/read data.
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority with requester 0 always winning.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 access request, held until m0_ack
- m0_addr  in  8  requester 0 IO offset
- m0_we  in  1  requester 0 write
- m0_rd  in  1  requester 0 read
- m0_wdata  in  DATA_WIDTH  requester 0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; request rejected
- m0_rdata  out  DATA_WIDTH  read data, valid while m0_ack=1
- m1_req, m1_addr, m1_we, m1_rd, m1_wdata, m1_ack, m1_err, m1_rdata  same as m0_* for requester 1
- io_addr  out  8  IO offset to IO unit
- io_dout  out  DATA_WIDTH  write data to IO unit
- io_din  in  DATA_WIDTH  read data from IO unit (combinational in io_addr)
- io_we  out  1  write strobe
- io_rd  out  1  read strobe
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, last-grant pointer = 1 (so requester 0 wins the first tie).
- Bus outputs are registers. io_we and io_rd are 0 in every state other than BUS.
- FSM states: IDLE, BUS, ACK.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise select a winner. With RR=1 and both req, the winner is the requester not in the last-grant pointer. With RR=0, requester 0 wins. With one req, that requester wins.
  - Latch the winner's addr, wdata, we and rd, and update the pointer to the winner.
  - Error check: reject if addr[1:0]!=0, addr>8'h18, or we==rd (both 0 or both 1).
  - Valid request: go to BUS. Rejected request: go to ACK with err set; no bus cycle is issued.
- BUS, exactly one cycle:
  - io_addr/io_dout/io_we/io_rd carry the latched request.
  - If it is a read, io_din is captured into the winner's rdata register at the end of the cycle.
  - Next state is ACK.
- ACK, exactly one cycle:
  - Winner's ack=1; err as decided; rdata holds the captured value (0 for writes and errors).
  - The other requester's ack=0 and its rdata is unchanged.
  - Next state is IDLE.
- Latency: req sampled in cycle N → bus strobe in cycle N+1 → ack in cycle N+2. Error latency: ack in cycle N+1.
- Requester rule: drop req (or present the next request) in the cycle after ack. The IDLE state following ACK re-arbitrates using the updated inputs.
- Throughput: at most one access per 3 cycles. With both requesting continuously under RR=1, grants alternate strictly 0,1,0,1…
- Inputs of the non-granted requester are ignored. Changes to the granted requester's inputs after the IDLE latch have no effect.
- A req with no strobe change is still arbitrated. A requester that drops req before ack gets no cancel; the access completes and the ack is still pulsed.
- Reset mid-operation (any state): immediate return to the reset values; an in-flight strobe is dropped, and no ack is produced for it.

Test Plan:
- Single write: m0_req, addr 8'h00, we=1, wdata 32'h0000_A5A5 → io_we=1 with io_addr 8'h00 and io_dout 32'h0000_A5A5 exactly 1 cycle after req; m0_ack=1 and m0_err=0 2 cycles after req; m1_ack stays 0.
- Single read: m1_req, addr 8'h14, rd=1, io_din driven to 32'h0000_1234 → io_rd high for exactly one cycle; m1_ack with m1_rdata 32'h0000_1234; io_rd is never high twice.
- Contention under RR=1: both requesters hold req for 4 transactions → grant order 0,1,0,1; acks 3 cycles apart. Under RR=0, the same stimulus gives 0,0,0,0 and requester 1 starves.
- Errors: m0 addr 8'h06; addr 8'h1C; we=rd=1 → m0_ack and m0_err in the cycle after req, with io_we/io_rd staying 0 throughout.
- Reset mid-BUS: assert rstn=0 while io_we=1 → io_we and busy go to 0 immediately, no ack is produced; after release, the first tie is granted to requester 0.
